// File: rtl/speed_ctrl_pkg.sv
// rtl/speed_ctrl_pkg.sv - shared speed codes, FSM encodings and helpers for the CPU speed sequencer
//
// Purpose: common definitions used by cpu_speed_sequencer and slow_hold_timer.
// Contents:
//   speed_code_t           2-bit CPU speed code
//   SPEED_3M5..SPEED_28M   speed code values
//   ST_IDLE/ST_WAIT_SAFE/ST_DONE  sequencer state encodings
//   to_cpu_speed()         maps a speed code onto the 4-bit clock-enable selector

package speed_ctrl_pkg;

   typedef logic [1:0] speed_code_t;

   localparam speed_code_t SPEED_3M5 = 2'b00;
   localparam speed_code_t SPEED_7M  = 2'b01;
   localparam speed_code_t SPEED_14M = 2'b10;
   localparam speed_code_t SPEED_28M = 2'b11;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_SAFE = 2'd1;
   localparam logic [1:0] ST_DONE      = 2'd2;

   // The selector has room for more rates; bits [3:2] stay zero for this core.
   function automatic logic [3:0] to_cpu_speed(input speed_code_t code);
      return {2'b00, code};
   endfunction

endpackage

// File: rtl/slow_hold_timer.sv
// rtl/slow_hold_timer.sv - keeps 3.5 MHz forced while a slow-only peripheral is active plus a hold-off
//
// Purpose: raises slow_forced while force_slow is high and keeps it raised for
// HOLD_PULSES clk35en pulses after force_slow falls.
// Ports:
//   clk          in  28 MHz master clock
//   rst          in  synchronous active-high reset
//   clk35en      in  3.5 MHz phase enable (hold counter tick)
//   force_slow   in  level, slow-only peripheral active
//   slow_forced  out effective speed must be 3.5 MHz

module slow_hold_timer
   import speed_ctrl_pkg::*;
#(
   parameter int HOLD_PULSES = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clk35en,
   input  logic force_slow,
   output logic slow_forced
);

   localparam int HW = $clog2(HOLD_PULSES + 1);

   logic [HW-1:0] hold_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt    <= '0;
         slow_forced <= 1'b0;
      end else if (force_slow) begin
         hold_cnt    <= HW'(HOLD_PULSES);
         slow_forced <= 1'b1;
      end else if (hold_cnt == '0) begin
         slow_forced <= 1'b0;
      end else if (clk35en) begin
         hold_cnt <= hold_cnt - HW'(1);
         // Release on the same edge the counter lands on zero.
         if (hold_cnt == HW'(1)) begin
            slow_forced <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpu_speed_sequencer.sv
// rtl/cpu_speed_sequencer.sv - commits CPU speed changes only at safe 3.5 MHz phase points
//
// Purpose: accepts speed requests, holds the committed 2-bit speed code and
// changes it only on a clk35en pulse with the Z80 bus idle (or after
// SAFE_TIMEOUT busy pulses), so the CPU clock enable never truncates a T-state.
// Optional feature macro: SPEED_AUTOSLOW_EN (forces 3.5 MHz while force_slow
// is active and for HOLD_PULSES clk35en pulses afterwards).
// Ports:
//   clk              in  28 MHz master clock
//   rst              in  synchronous active-high reset
//   clk35en          in  3.5 MHz phase enable, one cycle wide
//   cpu_mreq_n       in  Z80 MREQ, active low
//   cpu_iorq_n       in  Z80 IORQ, active low
//   speed_req_valid  in  speed request present
//   speed_req_value  in  requested speed code
//   speed_req_ready  out request accepted when valid && ready
//   force_slow       in  slow-only peripheral active
//   cpu_speed        out selector for the clock-enable generator
//   speed_applied    out one-cycle pulse after a commit
//   slow_forced      out effective target currently forced to 3.5 MHz

module cpu_speed_sequencer
   import speed_ctrl_pkg::*;
#(
   parameter int SAFE_TIMEOUT = 8,
   parameter int HOLD_PULSES  = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk35en,
   input  logic       cpu_mreq_n,
   input  logic       cpu_iorq_n,
   input  logic       speed_req_valid,
   input  logic [1:0] speed_req_value,
   output logic       speed_req_ready,
   input  logic       force_slow,
   output logic [3:0] cpu_speed,
   output logic       speed_applied,
   output logic       slow_forced
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(SAFE_TIMEOUT);

   logic [1:0]  state;
   speed_code_t target;
   speed_code_t cur;
   speed_code_t pending;
   speed_code_t eff;
   logic [7:0]  to_cnt;
   logic [7:0]  to_next;
   logic        bus_idle;
   logic        slow_forced_i;

`ifdef SPEED_AUTOSLOW_EN
   slow_hold_timer #(
      .HOLD_PULSES (HOLD_PULSES)
   ) u_slow_hold (
      .clk         (clk),
      .rst         (rst),
      .clk35en     (clk35en),
      .force_slow  (force_slow),
      .slow_forced (slow_forced_i)
   );
`else
   localparam int unused_hold_pulses = HOLD_PULSES;
   logic unused_force_slow;
   assign unused_force_slow = force_slow;
   assign slow_forced_i     = 1'b0;
`endif

   assign eff      = slow_forced_i ? SPEED_3M5 : target;
   assign bus_idle = cpu_mreq_n & cpu_iorq_n;
   assign to_next  = to_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         target  <= SPEED_3M5;
         cur     <= SPEED_3M5;
         pending <= SPEED_3M5;
         to_cnt  <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (speed_req_valid) begin
                  target <= speed_req_value;
               end
               // Uses the registered target, so a new request is seen one edge later.
               if (eff != cur) begin
                  pending <= eff;
                  to_cnt  <= 8'd0;
                  state   <= ST_WAIT_SAFE;
               end
            end
            ST_WAIT_SAFE: begin
               pending <= eff;
               if (eff == cur) begin
                  state <= ST_IDLE;
               end else if (clk35en) begin
                  // A bus cycle that never ends must not block the change forever.
                  if (bus_idle || (to_next == TIMEOUT_LIM)) begin
                     cur   <= pending;
                     state <= ST_DONE;
                  end else begin
                     to_cnt <= to_next;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign speed_req_ready = (state == ST_IDLE);
   assign speed_applied   = (state == ST_DONE);
   assign cpu_speed       = to_cpu_speed(cur);
   assign slow_forced     = slow_forced_i;

endmodule

// File: tb/tb_cpu_speed_sequencer.sv
// tb/tb_cpu_speed_sequencer.sv - directed self-checking bench for cpu_speed_sequencer

module tb_cpu_speed_sequencer;

   localparam int SAFE_TIMEOUT = 8;
   localparam int HOLD_PULSES  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk35en = 1'b0;
   logic       cpu_mreq_n = 1'b1;
   logic       cpu_iorq_n = 1'b1;
   logic       speed_req_valid = 1'b0;
   logic [1:0] speed_req_value = 2'b00;
   logic       speed_req_ready;
   logic       force_slow = 1'b0;
   logic [3:0] cpu_speed;
   logic       speed_applied;
   logic       slow_forced;

   int n_cmp = 0;
   int n_err = 0;
   int pulse_cnt = 0;
   int applied_cnt = 0;
   logic [3:0] exp_q[$];

   cpu_speed_sequencer #(
      .SAFE_TIMEOUT (SAFE_TIMEOUT),
      .HOLD_PULSES  (HOLD_PULSES)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .clk35en         (clk35en),
      .cpu_mreq_n      (cpu_mreq_n),
      .cpu_iorq_n      (cpu_iorq_n),
      .speed_req_valid (speed_req_valid),
      .speed_req_value (speed_req_value),
      .speed_req_ready (speed_req_ready),
      .force_slow      (force_slow),
      .cpu_speed       (cpu_speed),
      .speed_applied   (speed_applied),
      .slow_forced     (slow_forced)
   );

   always #5 clk = ~clk;

   // Two enables per 16 clk cycles.
   initial begin
      forever begin
         repeat (7) @(negedge clk);
         clk35en = 1'b1;
         @(negedge clk);
         clk35en = 1'b0;
      end
   end

   always @(posedge clk) begin
      if (clk35en) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every commit pulse must match the next expected speed.
   always @(negedge clk) begin
      if (!rst && speed_applied) begin
         applied_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_applied observed=%0h expected=none", cpu_speed);
         end else begin
            chk("scoreboard_speed", {28'd0, cpu_speed}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic request(input logic [1:0] v);
      speed_req_valid = 1'b1;
      speed_req_value = v;
      tick();
      speed_req_valid = 1'b0;
   endtask

   task automatic wait_pulse(input int tgt);
      int n = 0;
      while (pulse_cnt < tgt && n < 40) begin
         tick();
         n++;
      end
      chk("pulse_wait", pulse_cnt >= tgt, 1);
   endtask

   task automatic wait_applied(input string tag);
      int a = applied_cnt;
      int n = 0;
      while (applied_cnt == a && n < 100) begin
         tick();
         n++;
      end
      chk(tag, applied_cnt != a, 1);
   endtask

   initial begin
      int p;
      int a0;

      // Reset values
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_cpu_speed", cpu_speed, 4'b0000);
      chk("rst_ready", speed_req_ready, 1);
      chk("rst_applied", speed_applied, 0);
      chk("rst_slow_forced", slow_forced, 0);

      // Request 10 with the bus idle
      request(2'b10);
      exp_q.push_back(4'b0010);
      chk("ready_after_E0", speed_req_ready, 1);
      tick();
      chk("ready_drop_E1", speed_req_ready, 0);
      p = pulse_cnt;
      wait_pulse(p + 1);
      chk("speed_10_next_pulse", cpu_speed, 4'b0010);
      chk("applied_high", speed_applied, 1);
      tick();
      chk("applied_one_cycle", speed_applied, 0);
      chk("ready_back", speed_req_ready, 1);

      // Request 11 with MREQ held low: timeout commit on the 8th pulse
      cpu_mreq_n = 1'b0;
      request(2'b11);
      exp_q.push_back(4'b0011);
      tick();
      chk("ready_drop_busy", speed_req_ready, 0);
      p = pulse_cnt;
      for (int k = 1; k <= SAFE_TIMEOUT; k++) begin
         wait_pulse(p + k);
         if (k < SAFE_TIMEOUT) chk("no_early_commit", cpu_speed, 4'b0010);
         else                  chk("timeout_commit", cpu_speed, 4'b0011);
      end
      cpu_mreq_n = 1'b1;
      tick();

      // Request equal to the current speed
      a0 = applied_cnt;
      request(2'b11);
      repeat (4) begin
         tick();
         chk("same_req_ready", speed_req_ready, 1);
      end
      chk("same_req_no_pulse", applied_cnt, a0);
      chk("same_req_speed", cpu_speed, 4'b0011);

      // Reset during WAIT_SAFE
      cpu_mreq_n = 1'b0;
      request(2'b01);
      tick();
      chk("wait_safe_entered", speed_req_ready, 0);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      chk("midrst_speed", cpu_speed, 4'b0000);
      chk("midrst_ready", speed_req_ready, 1);
      chk("midrst_applied", speed_applied, 0);
      cpu_mreq_n = 1'b1;
      a0 = applied_cnt;
      repeat (20) tick();
      chk("midrst_no_pulse", applied_cnt, a0);
      chk("midrst_speed_hold", cpu_speed, 4'b0000);

`ifdef SPEED_AUTOSLOW_EN
      // Forced slow with a 4-pulse hold
      request(2'b11);
      exp_q.push_back(4'b0011);
      wait_applied("fast_applied");
      chk("fast_speed", cpu_speed, 4'b0011);
      force_slow = 1'b1;
      exp_q.push_back(4'b0000);
      tick();
      chk("slow_forced_rise", slow_forced, 1);
      repeat (9) tick();
      force_slow = 1'b0;
      p = pulse_cnt;
      wait_pulse(p + HOLD_PULSES - 1);
      chk("hold_still_forced", slow_forced, 1);
      chk("forced_speed", cpu_speed, 4'b0000);
      wait_pulse(p + HOLD_PULSES);
      chk("hold_released", slow_forced, 0);
      exp_q.push_back(4'b0011);
      wait_applied("return_applied");
      chk("return_speed", cpu_speed, 4'b0011);
`else
      // force_slow has no effect when the feature is left out
      request(2'b01);
      exp_q.push_back(4'b0001);
      wait_applied("speed_01_applied");
      chk("speed_01", cpu_speed, 4'b0001);
      a0 = applied_cnt;
      for (int i = 0; i < 3; i++) begin
         force_slow = 1'b1;
         repeat (6) begin
            tick();
            chk("slow_forced_tied", slow_forced, 0);
            chk("speed_unaffected", cpu_speed, 4'b0001);
         end
         force_slow = 1'b0;
         repeat (3) tick();
      end
      chk("force_no_pulse", applied_cnt, a0);
`endif

      repeat (5) tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
